// File: rtl/psk_tx_modulator.sv
// BPSK transmitter: framed, LSB-first bytes, one bit per SYM_LEN-clock symbol,
// XORed onto an NCO square carrier. Frame = alternating preamble, data bytes, idle gap.
module psk_tx_modulator #(
    parameter int CW_WIDTH      = 13,
    parameter int SYM_LEN       = 256,
    parameter int PREAMBLE_SYMS = 8,
    parameter int GAP_SYMS      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CW_WIDTH-1:0] control_word,
    input  logic [7:0]          tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                sig,
    output logic                i_carrier,
    output logic                sym_stb,
    output logic                busy
);
    localparam int SCW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam int PCW = $clog2(PREAMBLE_SYMS + 1);
    localparam int GCW = $clog2(GAP_SYMS + 1);
    localparam logic [SCW-1:0] SYM_LAST = SCW'(SYM_LEN - 1);
    localparam logic [PCW-1:0] PRE_LAST = PCW'(PREAMBLE_SYMS - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_SYMS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t              state_reg;
    logic [CW_WIDTH-1:0] phase_reg;
    logic [SCW-1:0]      sym_cnt_reg;
    logic [PCW-1:0]      pre_cnt_reg;
    logic [GCW-1:0]      gap_cnt_reg;
    logic [2:0]          bit_cnt_reg;
    logic [7:0]          hold_reg;
    logic [7:0]          shift_reg;
    logic                buf_full_reg;
    logic                cur_bit_reg;

    assign sym_stb   = (sym_cnt_reg == SYM_LAST);
    assign tx_ready  = !buf_full_reg;
    assign i_carrier = phase_reg[CW_WIDTH-1];
    assign sig       = i_carrier ^ cur_bit_reg;
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            sym_cnt_reg  <= '0;
            pre_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            hold_reg     <= '0;
            shift_reg    <= '0;
            buf_full_reg <= 1'b0;
            cur_bit_reg  <= 1'b0;
        end else begin
            phase_reg   <= phase_reg + control_word;
            sym_cnt_reg <= sym_stb ? '0 : sym_cnt_reg + SCW'(1);

            // Accepts only happen while the buffer is empty, so they can never
            // collide with the buffer being drained into the shifter below.
            if (tx_valid && !buf_full_reg) begin
                hold_reg     <= tx_data;
                buf_full_reg <= 1'b1;
            end

            if (sym_stb) begin
                case (state_reg)
                    IDLE: begin
                        if (buf_full_reg) begin
                            state_reg   <= PREAMBLE;
                            pre_cnt_reg <= '0;
                            cur_bit_reg <= 1'b1;
                        end else begin
                            cur_bit_reg <= 1'b0;
                        end
                    end
                    PREAMBLE: begin
                        if (pre_cnt_reg == PRE_LAST) begin
                            state_reg    <= DATA;
                            shift_reg    <= hold_reg;
                            buf_full_reg <= 1'b0;
                            cur_bit_reg  <= hold_reg[0];
                            bit_cnt_reg  <= '0;
                        end else begin
                            pre_cnt_reg <= pre_cnt_reg + PCW'(1);
                            cur_bit_reg <= !cur_bit_reg;
                        end
                    end
                    DATA: begin
                        if (bit_cnt_reg != 3'd7) begin
                            shift_reg   <= shift_reg >> 1;
                            cur_bit_reg <= shift_reg[1];
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end else if (buf_full_reg) begin
                            // Back-to-back byte: continue the frame without a new preamble.
                            shift_reg    <= hold_reg;
                            buf_full_reg <= 1'b0;
                            cur_bit_reg  <= hold_reg[0];
                            bit_cnt_reg  <= '0;
                        end else begin
                            state_reg   <= GAP;
                            cur_bit_reg <= 1'b0;
                            gap_cnt_reg <= '0;
                        end
                    end
                    GAP: begin
                        cur_bit_reg <= 1'b0;
                        if (gap_cnt_reg == GAP_LAST) begin
                            state_reg <= IDLE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + GCW'(1);
                        end
                    end
                    default: begin
                        state_reg   <= IDLE;
                        cur_bit_reg <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_psk_tx_modulator.sv
// Bench for psk_tx_modulator: directed scenarios plus random traffic, all checked
// against a symbol-queue model of the framing rules and an integer NCO.
module tb_psk_tx_modulator;
    localparam int CWW  = 13;
    localparam int SYML = 4;
    localparam int PRE  = 8;
    localparam int GAPS = 2;
    localparam int K_IDLE = 0, K_PRE = 1, K_DATA = 2, K_GAP = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [CWW-1:0] control_word = '0;
    logic [7:0]     tx_data = '0;
    logic           tx_valid = 1'b0;
    logic           tx_ready, sig, i_carrier, sym_stb, busy;

    psk_tx_modulator #(
        .CW_WIDTH(CWW), .SYM_LEN(SYML), .PREAMBLE_SYMS(PRE), .GAP_SYMS(GAPS)
    ) dut (
        .clk(clk), .rst(rst), .control_word(control_word), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .sig(sig), .i_carrier(i_carrier),
        .sym_stb(sym_stb), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a queue of scheduled symbols, refilled at symbol boundaries.
    typedef struct { bit b; bit load; int kind; } sym_t;
    sym_t       sym_q[$];
    int         m_phase = 0;
    int         m_cyc = 0;
    bit         m_full = 0;
    logic [7:0] m_buf = 0;
    bit         m_cur = 0;
    int         m_kind = K_IDLE;

    bit         log_en = 0;
    bit         log_q[$];

    task automatic push_sym(input bit b, input bit load, input int kind);
        sym_t e;
        e.b = b; e.load = load; e.kind = kind;
        sym_q.push_back(e);
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) push_sym(v[i], i == 0, K_DATA);
    endtask

    task automatic model_edge();
        bit old_full;
        sym_t e;
        if (rst) begin
            m_phase = 0; m_cyc = 0; m_full = 0; m_buf = 0; m_cur = 0; m_kind = K_IDLE;
            sym_q.delete();
            return;
        end
        old_full = m_full;
        if (m_cyc % SYML == SYML - 1) begin
            if (sym_q.size() == 0) begin
                if (m_kind == K_DATA && m_full) begin
                    push_byte(m_buf);
                end else if (m_kind == K_DATA) begin
                    for (int i = 0; i < GAPS; i++) push_sym(1'b0, 1'b0, K_GAP);
                end else if (m_kind == K_IDLE && m_full) begin
                    for (int i = 0; i < PRE; i++) push_sym((i % 2) == 0, 1'b0, K_PRE);
                    push_byte(m_buf);
                end
            end
            if (sym_q.size() != 0) begin
                e = sym_q.pop_front();
                m_cur = e.b; m_kind = e.kind;
                if (e.load) m_full = 0;
            end else begin
                m_cur = 0; m_kind = K_IDLE;
            end
        end
        if (tx_valid && !old_full) begin
            m_buf = tx_data; m_full = 1;
        end
        m_phase = (m_phase + int'(control_word)) % (1 << CWW);
        m_cyc++;
    endtask

    // One clock: update the model at the edge, compare every output at the falling edge.
    task automatic step();
        bit car;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        car = (m_phase >= (1 << (CWW - 1)));
        check("sig", sig, car ^ m_cur);
        check("i_carrier", i_carrier, car);
        check("tx_ready", tx_ready, !m_full);
        check("busy", busy, m_kind != K_IDLE);
        check("sym_stb", sym_stb, (m_cyc % SYML) == SYML - 1);
        if (log_en && busy && (m_cyc % SYML) == 0) log_q.push_back(sig ^ i_carrier);
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!tx_ready && n < limit) begin step(); n++; end
        if (!tx_ready) check("wait_ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] v);
        wait_ready(200);
        tx_valid = 1'b1; tx_data = v;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic wait_frame_end();
        int n = 0;
        while (!busy && n < 20) begin step(); n++; end
        if (!busy) check("busy_rise_timeout", 0, 1);
        n = 0;
        while (busy && n < 600) begin step(); n++; end
        if (busy) check("busy_fall_timeout", 1, 0);
    endtask

    initial begin
        int first_stb, second_stb, highs, acc;
        logic [7:0] exp_a5 [18];
        bit exp_b2b [16];

        // Reset held 3 cycles with a running carrier word.
        control_word = 13'd512;
        rst = 1'b1;
        repeat (3) step();
        check("rst_sig", sig, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        first_stb = -1; second_stb = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (sym_stb && first_stb < 0) first_stb = i;
            else if (sym_stb && second_stb < 0) second_stb = i;
        end
        check("first_sym_stb_cycle", first_stb, 3);
        check("second_sym_stb_cycle", second_stb, 7);

        // Carrier: cw=512 gives a 16-clock square wave, 16 high clocks per 32.
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (i_carrier) highs++;
        end
        check("carrier_duty", highs, 16);

        // Single byte, baseband.
        control_word = '0;
        exp_a5 = '{1,0,1,0,1,0,1,0, 1,0,1,0,0,1,0,1, 0,0};
        log_q.delete(); log_en = 1;
        send(8'hA5);
        wait_frame_end();
        log_en = 0;
        check("a5_symbols", log_q.size(), 18);
        for (int i = 0; i < 18 && i < log_q.size(); i++) check($sformatf("a5_sym%0d", i), log_q[i], exp_a5[i][0]);

        // Back-to-back bytes: second byte follows without a new preamble.
        control_word = 13'd512;
        exp_b2b = '{1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1};
        log_q.delete(); log_en = 1;
        send(8'h01);
        wait_ready(200);
        send(8'h80);
        check("b2b_ready_low_after_accept", tx_ready, 0);
        wait_frame_end();
        log_en = 0;
        check("b2b_symbols", log_q.size(), PRE + 16 + GAPS);
        for (int i = 0; i < 16 && i + PRE < log_q.size(); i++) check($sformatf("b2b_sym%0d", i), log_q[i + PRE], exp_b2b[i]);

        // Stall: tx_valid held while buffer is full yields exactly one more accept.
        send(8'h55);
        tx_valid = 1'b1; tx_data = 8'h33; acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx_ready) acc++;
            step();
        end
        tx_valid = 1'b0;
        check("stall_accepts", acc, 1);
        wait_frame_end();

        // Reset in the middle of DATA with a byte buffered.
        send(8'hC3);
        wait_ready(200);
        send(8'h0F);
        for (int k = 0; k < 3; k++) begin
            step();
            while ((m_cyc % SYML) != 0) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_sig", sig, 0);
        check("midrst_carrier", i_carrier, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", tx_ready, 1);
        log_q.delete(); log_en = 1;
        send(8'h96);
        wait_frame_end();
        log_en = 0;
        check("post_rst_symbols", log_q.size(), PRE + 8 + GAPS);
        for (int i = 0; i < PRE && i < log_q.size(); i++) check($sformatf("post_rst_pre%0d", i), log_q[i], (i % 2) == 0);

        // Random traffic, carrier changes and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            bit accepted;
            if ($urandom_range(0, 49) == 0)
                control_word = ($urandom_range(0, 3) == 0) ? '0 : CWW'($urandom);
            if (!tx_valid && $urandom_range(0, 5) == 0) begin
                tx_valid = 1'b1; tx_data = 8'($urandom);
            end
            rst = ($urandom_range(0, 699) == 0);
            accepted = tx_valid && tx_ready && !rst;
            step();
            rst = 1'b0;
            if (accepted) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        repeat (200) step();
        check("final_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psk_tx_modulator.md
Name: psk_tx_modulator

Overview:
- Transmit-side counterpart to the PSK correlator receiver. Accepts bytes over a valid/ready handshake and frames each burst with an alternating preamble.
- Serialises data LSB-first, one bit per fixed-length symbol, and outputs a 1-bit BPSK signal: an NCO square carrier XOR the current bit.
- Drives the line (or loopback) that the receiver's I/Q correlators integrate. Symbol timing, carrier control word and preamble are matched to the receiver.

Parameters:
- CW_WIDTH, 13, width of the phase accumulator and control_word.
- SYM_LEN, 256, clocks per symbol, ≥2.
- PREAMBLE_SYMS, 8, preamble symbols per frame, ≥1. Pattern is 1,0,1,0,… starting with 1.
- GAP_SYMS, 2, unmodulated symbols (bit 0) after the last byte before returning to IDLE, ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- control_word  in  CW_WIDTH  phase increment per clock; carrier freq = clk*cw/2^CW_WIDTH
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding buffer empty; a byte is accepted on tx_valid&tx_ready
- sig  out  1  modulated output = i_carrier XOR cur_bit
- i_carrier  out  1  unmodulated carrier (phase MSB), for loopback/debug
- sym_stb  out  1  one-cycle pulse on the last clock of every symbol
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - phase=0, sym_cnt=0, state=IDLE, cur_bit=0, buf_full=0.
  - Hence sig=0, i_carrier=0, tx_ready=1, busy=0, sym_stb=0 (unless SYM_LEN=1, which is disallowed).
- NCO:
  - phase <= phase + control_word every cycle, modulo 2^CW_WIDTH; continuous across symbols.
  - control_word may change at any cycle; there is no phase reset.
  - i_carrier = phase[MSB].
  - cw=0 gives a constant 0 carrier, so sig equals the baseband bit.
- Symbol timer:
  - sym_cnt counts 0..SYM_LEN-1 and wraps; it is free-running, including in IDLE.
  - sym_stb = (sym_cnt==SYM_LEN-1).
  - All state and cur_bit updates happen only on the clock edge where sym_stb=1, so every symbol occupies exactly SYM_LEN cycles starting at sym_cnt=0.
- Buffer:
  - One-byte holding register.
  - tx_ready = !buf_full, driven from the register only, with no combinational path from tx_valid.
  - On accept: buf <= tx_data, buf_full <= 1.
  - Held tx_valid while tx_ready=0 is ignored; no duplicate accept.
- FSM states (evaluated at sym_stb):
  - IDLE: if buf_full, go to PREAMBLE, pre_cnt=0, cur_bit=1. Otherwise cur_bit=0.
  - PREAMBLE:
    - cur_bit toggles each symbol.
    - After PREAMBLE_SYMS symbols: shift <= buf, buf_full <= 0, cur_bit = buf[0], bit_cnt=0, go to DATA.
  - DATA:
    - Each symbol: shift right, cur_bit = next LSB, bit_cnt++.
    - After bit 7's symbol, if buf_full: load the next byte directly (no preamble) and stay in DATA, cur_bit = buf[0], buf_full <= 0.
    - Otherwise go to GAP, cur_bit=0, gap_cnt=0.
  - GAP:
    - cur_bit=0 for GAP_SYMS symbols, then IDLE.
    - If a byte arrives during GAP, the gap still completes; the next frame starts with a preamble.
- Accept and buffer load never coincide: load only happens when buf_full=1, and then tx_ready=0.
- Frame start latency: a byte accepted while IDLE is transmitted starting at the next symbol boundary after buf_full=1. The preamble begins 1..SYM_LEN cycles after the accept cycle.
- sig = i_carrier XOR cur_bit, a combinational XOR of two flops. Bit 1 is a 180° carrier phase shift.
- busy = 1 from the first PREAMBLE symbol through the last GAP symbol.
- Reset mid-frame returns all registers to reset values on the next edge. The buffered byte and the in-flight byte are discarded and no partial symbols follow.

Test Plan:
- Reset:
  - Stimulus: assert rst 3 cycles; SYM_LEN=4, cw=512.
  - Required: sig=0, tx_ready=1, busy=0; sym_stb first high at cycle 3 after release, then every 4 cycles.
- Single byte baseband:
  - Stimulus: cw=0, SYM_LEN=4, PREAMBLE_SYMS=8, GAP_SYMS=2; send 0xA5 while IDLE.
  - Required, each value held 4 cycles: sig = 1,0,1,0,1,0,1,0 | 1,0,1,0,0,1,0,1 | 0,0.
  - Required: busy falls at the end of the gap; tx_ready returns to 1 when DATA loads.
- Carrier:
  - Stimulus: cw=512, CW_WIDTH=13.
  - Required: i_carrier period 16 clocks (8 high, 8 low); sig==i_carrier when idle and during 0 bits, sig==~i_carrier during 1 bits.
- Back-to-back:
  - Stimulus: send 0x01, then 0x80 during the first byte's DATA.
  - Required: 16 data symbols contiguous, 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1, with no second preamble.
  - Required: tx_ready=0 from the second accept until its load.
- Stall:
  - Stimulus: hold tx_valid=1 with 0x33 for 40 cycles while the buffer is full.
  - Required: exactly one extra accept, when buf_full clears.
- Reset mid-DATA:
  - Stimulus: pulse rst at bit 3 with a byte buffered.
  - Required: next cycle sig=i_carrier=0, busy=0, tx_ready=1.
  - Required: a new send starts with the full preamble.
